// File: rtl/timing_pkg.sv
// Shared types for the per-bank DRAM timing tracker: the 5-bit bank state
// encoding, default timing constants and the command-priority encoder.
package timing_pkg;

  localparam int DEF_BL   = 8;
  localparam int DEF_TRCD = 15;
  localparam int DEF_TWR  = 12;
  localparam int DEF_TRTP = 6;
  localparam int DEF_TRP  = 16;
  localparam int DEF_TRFC = 34;

  typedef enum logic [4:0] {
    ST_IDLE         = 5'd0,
    ST_ACTIVATING   = 5'd1,
    ST_BANK_ACTIVE  = 5'd2,
    ST_ACTIVE_PD    = 5'd3,
    ST_READING      = 5'd4,
    ST_READING_AP   = 5'd5,
    ST_WRITING      = 5'd6,
    ST_WRITING_AP   = 5'd7,
    ST_PRECHARGING  = 5'd8,
    ST_REFRESHING   = 5'd9,
    ST_SELF_REFRESH = 5'd10,
    ST_PRECHARGE_PD = 5'd11,
    ST_DEEP_PD      = 5'd12,
    ST_MODE_REG     = 5'd13
  } bank_state_e;

  // Single winning command per bank after priority resolution. Strobes with
  // identical effect (PD/CKEL, PDX/CKEH, MRR/MRW/CFG) share one code.
  typedef enum logic [3:0] {
    CMD_NONE, CMD_PRA, CMD_PR, CMD_REF, CMD_ACT, CMD_WRA, CMD_WR, CMD_RDA,
    CMD_RD, CMD_BST, CMD_SRF, CMD_PDE, CMD_PDX, CMD_DPD, CMD_DPDX, CMD_MR
  } bank_cmd_e;

  // Strobes as seen by one bank: bank-addressed ones are already qualified
  // by the bg/ba match, global ones are broadcast unchanged.
  typedef struct packed {
    logic act;
    logic bst;
    logic cfg;
    logic ckeh;
    logic ckel;
    logic dpd;
    logic dpdx;
    logic mrr;
    logic mrw;
    logic pd;
    logic pdx;
    logic pr;
    logic pra;
    logic rd;
    logic rda;
    logic refresh;
    logic srf;
    logic wr;
    logic wra;
  } cmd_strobes_t;

  // Highest-priority asserted strobe wins; if the winner is not accepted by
  // the bank's current state the whole cycle is a no-op for that bank.
  function automatic bank_cmd_e prio_cmd(input cmd_strobes_t s);
    bank_cmd_e c;
    if      (s.pra)                   c = CMD_PRA;
    else if (s.pr)                    c = CMD_PR;
    else if (s.refresh)               c = CMD_REF;
    else if (s.act)                   c = CMD_ACT;
    else if (s.wra)                   c = CMD_WRA;
    else if (s.wr)                    c = CMD_WR;
    else if (s.rda)                   c = CMD_RDA;
    else if (s.rd)                    c = CMD_RD;
    else if (s.bst)                   c = CMD_BST;
    else if (s.srf)                   c = CMD_SRF;
    else if (s.pd || s.ckel)          c = CMD_PDE;
    else if (s.pdx || s.ckeh)         c = CMD_PDX;
    else if (s.dpd)                   c = CMD_DPD;
    else if (s.dpdx)                  c = CMD_DPDX;
    else if (s.mrr || s.mrw || s.cfg) c = CMD_MR;
    else                              c = CMD_NONE;
    return c;
  endfunction

endpackage

// File: rtl/timing_fsm_bank.sv
// One bank's state machine plus its 8-bit residency counter.
// A timed state is entered with its counter loaded to the residency in clocks
// and leaves on the edge where the counter would reach 0 (so a load of N keeps
// the state visible for N clocks). Accepted commands take precedence over
// expiry in the same cycle.
// Optional build macro ROWCLONE_EN: ACT to an active bank re-enters Activating.
module bank_timing_fsm
  import timing_pkg::*;
#(
  parameter int BL   = DEF_BL,
  parameter int TRCD = DEF_TRCD,
  parameter int TWR  = DEF_TWR,
  parameter int TRTP = DEF_TRTP,
  parameter int TRP  = DEF_TRP,
  parameter int TRFC = DEF_TRFC
) (
  input  logic         clk,
  input  logic         rst,
  input  cmd_strobes_t cmd,
  output bank_state_e  state
);

  localparam logic [7:0] T_BURST = 8'(BL / 2);
  localparam logic [7:0] T_RDAP  = 8'(BL / 2 + TRTP);
  localparam logic [7:0] T_WRAP  = 8'(BL / 2 + TWR);
  localparam logic [7:0] T_RCD   = 8'(TRCD);
  localparam logic [7:0] T_RP    = 8'(TRP);
  localparam logic [7:0] T_RFC   = 8'(TRFC);

  bank_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  bank_cmd_e   win;
  logic        expire;

  assign win    = prio_cmd(cmd);
  assign expire = (cnt_q <= 8'd1);
  assign state  = state_q;

  // State and counter registers; reset parks the bank in Idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and counter: default holds state and counts down to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
    case (state_q)
      ST_IDLE: begin
        case (win)
          CMD_ACT: begin state_d = ST_ACTIVATING;   cnt_d = T_RCD; end
          CMD_REF: begin state_d = ST_REFRESHING;   cnt_d = T_RFC; end
          CMD_SRF: begin state_d = ST_SELF_REFRESH; cnt_d = '0;    end
          CMD_PDE: begin state_d = ST_PRECHARGE_PD; cnt_d = '0;    end
          CMD_DPD: begin state_d = ST_DEEP_PD;      cnt_d = '0;    end
          CMD_MR:  begin state_d = ST_MODE_REG;     cnt_d = 8'd1;  end
          default: ;
        endcase
      end
      ST_ACTIVATING: begin
        if (expire) begin state_d = ST_BANK_ACTIVE; cnt_d = '0; end
      end
      ST_BANK_ACTIVE: begin
        case (win)
          CMD_PRA, CMD_PR: begin state_d = ST_PRECHARGING; cnt_d = T_RP;    end
`ifdef ROWCLONE_EN
          CMD_ACT:         begin state_d = ST_ACTIVATING;  cnt_d = T_RCD;   end
`endif
          CMD_WRA:         begin state_d = ST_WRITING_AP;  cnt_d = T_WRAP;  end
          CMD_WR:          begin state_d = ST_WRITING;     cnt_d = T_BURST; end
          CMD_RDA:         begin state_d = ST_READING_AP;  cnt_d = T_RDAP;  end
          CMD_RD:          begin state_d = ST_READING;     cnt_d = T_BURST; end
          CMD_PDE:         begin state_d = ST_ACTIVE_PD;   cnt_d = '0;      end
          default: ;
        endcase
      end
      ST_READING, ST_WRITING: begin
        case (win)
          CMD_PR:  begin state_d = ST_PRECHARGING; cnt_d = T_RP;    end
          CMD_WR:  begin state_d = ST_WRITING;     cnt_d = T_BURST; end
          CMD_RD:  begin state_d = ST_READING;     cnt_d = T_BURST; end
          CMD_BST: begin state_d = ST_BANK_ACTIVE; cnt_d = '0;      end
          default: begin
            if (expire) begin state_d = ST_BANK_ACTIVE; cnt_d = '0; end
          end
        endcase
      end
      ST_READING_AP, ST_WRITING_AP: begin
        if (expire) begin state_d = ST_PRECHARGING; cnt_d = T_RP; end
      end
      ST_PRECHARGING, ST_REFRESHING, ST_MODE_REG: begin
        if (expire) begin state_d = ST_IDLE; cnt_d = '0; end
      end
      ST_SELF_REFRESH, ST_PRECHARGE_PD: begin
        if (win == CMD_PDX) begin state_d = ST_IDLE; cnt_d = '0; end
      end
      ST_ACTIVE_PD: begin
        if (win == CMD_PDX) begin state_d = ST_BANK_ACTIVE; cnt_d = '0; end
      end
      ST_DEEP_PD: begin
        if (win == CMD_DPDX) begin state_d = ST_IDLE; cnt_d = '0; end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/timing_fsm.sv
// Per-bank DRAM command/timing tracker. Decodes the bank-group/bank address,
// qualifies bank-addressed strobes to the selected bank, broadcasts global
// strobes, and exports the state of every bank on BankFSM.
// Optional build macro ROWCLONE_EN (handled inside bank_timing_fsm).
module timing_fsm
  import timing_pkg::*;
#(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int BL      = DEF_BL,
  parameter int TRCD    = DEF_TRCD,
  parameter int TWR     = DEF_TWR,
  parameter int TRTP    = DEF_TRTP,
  parameter int TRP     = DEF_TRP,
  parameter int TRFC    = DEF_TRFC
) (
  input  logic clk,
  input  logic reset,
  input  logic [((BGWIDTH > 0) ? BGWIDTH : 1)-1:0] bg,
  input  logic [BAWIDTH-1:0] ba,
  input  logic ACT,
  input  logic BST,
  input  logic CFG,
  input  logic CKEH,
  input  logic CKEL,
  input  logic DPD,
  input  logic DPDX,
  input  logic MRR,
  input  logic MRW,
  input  logic PD,
  input  logic PDX,
  input  logic PR,
  input  logic PRA,
  input  logic RD,
  input  logic RDA,
  input  logic REF,
  input  logic SRF,
  input  logic WR,
  input  logic WRA,
  output logic [(1 << BGWIDTH)-1:0][(1 << BAWIDTH)-1:0][4:0] BankFSM
);

  localparam int BANKGROUPS    = 1 << BGWIDTH;
  localparam int BANKSPERGROUP = 1 << BAWIDTH;

  for (genvar g = 0; g < BANKGROUPS; g++) begin : g_grp
    for (genvar a = 0; a < BANKSPERGROUP; a++) begin : g_bank
      logic         hit;
      cmd_strobes_t cmd;
      bank_state_e  st;

      // With no bank-group bits there is a single group and bg is ignored.
      if (BGWIDTH == 0) begin : g_nobg
        assign hit = (ba == BAWIDTH'(a));
      end else begin : g_bg
        assign hit = (bg == BGWIDTH'(g)) && (ba == BAWIDTH'(a));
      end

      assign cmd = '{
        act:     ACT & hit,
        bst:     BST & hit,
        cfg:     CFG,
        ckeh:    CKEH,
        ckel:    CKEL,
        dpd:     DPD,
        dpdx:    DPDX,
        mrr:     MRR,
        mrw:     MRW,
        pd:      PD,
        pdx:     PDX,
        pr:      PR & hit,
        pra:     PRA,
        rd:      RD & hit,
        rda:     RDA & hit,
        refresh: REF,
        srf:     SRF,
        wr:      WR & hit,
        wra:     WRA & hit
      };

      bank_timing_fsm #(
        .BL(BL), .TRCD(TRCD), .TWR(TWR), .TRTP(TRTP), .TRP(TRP), .TRFC(TRFC)
      ) u_bank (
        .clk   (clk),
        .rst   (reset),
        .cmd   (cmd),
        .state (st)
      );

      assign BankFSM[g][a] = st;
    end
  end

endmodule

// File: tb/tb_timing_fsm.sv
// Bench for timing_fsm: directed and random command streams against a
// schedule-based reference model; a monitor compares every cycle's BankFSM.
module tb_timing_fsm;

  localparam int NB = 16;
  localparam int W  = 80;

  // Timing from the block description, default build.
  localparam int BURST = 4;
  localparam int T_RCD = 15;
  localparam int T_WR  = 12;
  localparam int T_RTP = 6;
  localparam int T_RP  = 16;
  localparam int T_RFC = 34;

  // Strobe bit indices, lowest index = highest priority.
  localparam int C_PRA = 0, C_PR = 1, C_REF = 2, C_ACT = 3, C_WRA = 4, C_WR = 5;
  localparam int C_RDA = 6, C_RD = 7, C_BST = 8, C_SRF = 9, C_PD = 10, C_CKEL = 11;
  localparam int C_PDX = 12, C_CKEH = 13, C_DPD = 14, C_DPDX = 15, C_MRR = 16;
  localparam int C_MRW = 17, C_CFG = 18;
  localparam logic [18:0] ADDR_MASK = 19'((1 << C_PR) | (1 << C_ACT) | (1 << C_WRA) |
                                          (1 << C_WR) | (1 << C_RDA) | (1 << C_RD) | (1 << C_BST));

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] bg = '0, ba = '0;
  logic act = 0, bst = 0, cfg = 0, ckeh = 0, ckel = 0, dpd = 0, dpdx = 0, mrr = 0;
  logic mrw = 0, pd = 0, pdx = 0, pr = 0, pra = 0, rd = 0, rda = 0, refresh = 0;
  logic srf = 0, wr = 0, wra = 0;
  logic [3:0][3:0][4:0] bank_fsm;

  always #5 clk = ~clk;

  timing_fsm dut (
    .clk(clk), .reset(reset), .bg(bg), .ba(ba),
    .ACT(act), .BST(bst), .CFG(cfg), .CKEH(ckeh), .CKEL(ckel), .DPD(dpd),
    .DPDX(dpdx), .MRR(mrr), .MRW(mrw), .PD(pd), .PDX(pdx), .PR(pr), .PRA(pra),
    .RD(rd), .RDA(rda), .REF(refresh), .SRF(srf), .WR(wr), .WRA(wra),
    .BankFSM(bank_fsm)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cycle_no = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: each bank follows a schedule of (state, clocks) segments;
  // a duration of -1 means "stay until a command moves it".
  int m_st[NB];
  int m_rem[NB];
  int p_st[NB][2];
  int p_dur[NB][2];

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_st[b] = 0; m_rem[b] = -1;
      p_st[b][0] = -1; p_dur[b][0] = -1; p_st[b][1] = -1; p_dur[b][1] = -1;
    end
  endtask

  task automatic set_seq(input int b, input int s0, input int d0, input int s1,
                         input int d1, input int s2, input int d2);
    m_st[b] = s0; m_rem[b] = d0;
    p_st[b][0] = s1; p_dur[b][0] = d1; p_st[b][1] = s2; p_dur[b][1] = d2;
  endtask

  // Which command a bank in a given state accepts, and the schedule it starts.
  task automatic model_cmd(input int b, input int c, output bit took);
    took = 1'b1;
    case (m_st[b])
      0: case (c)
        C_ACT:              set_seq(b, 1, T_RCD, 2, -1, -1, -1);
        C_REF:              set_seq(b, 9, T_RFC, 0, -1, -1, -1);
        C_SRF:              set_seq(b, 10, -1, -1, -1, -1, -1);
        C_PD, C_CKEL:       set_seq(b, 11, -1, -1, -1, -1, -1);
        C_DPD:              set_seq(b, 12, -1, -1, -1, -1, -1);
        C_MRR, C_MRW, C_CFG: set_seq(b, 13, 1, 0, -1, -1, -1);
        default: took = 1'b0;
      endcase
      2: case (c)
        C_PRA, C_PR:  set_seq(b, 8, T_RP, 0, -1, -1, -1);
        C_RD:         set_seq(b, 4, BURST, 2, -1, -1, -1);
        C_RDA:        set_seq(b, 5, BURST + T_RTP, 8, T_RP, 0, -1);
        C_WR:         set_seq(b, 6, BURST, 2, -1, -1, -1);
        C_WRA:        set_seq(b, 7, BURST + T_WR, 8, T_RP, 0, -1);
        C_PD, C_CKEL: set_seq(b, 3, -1, -1, -1, -1, -1);
`ifdef ROWCLONE_EN
        C_ACT:        set_seq(b, 1, T_RCD, 2, -1, -1, -1);
`endif
        default: took = 1'b0;
      endcase
      4, 6: case (c)
        C_PR:  set_seq(b, 8, T_RP, 0, -1, -1, -1);
        C_RD:  set_seq(b, 4, BURST, 2, -1, -1, -1);
        C_WR:  set_seq(b, 6, BURST, 2, -1, -1, -1);
        C_BST: set_seq(b, 2, -1, -1, -1, -1, -1);
        default: took = 1'b0;
      endcase
      10, 11: if (c == C_PDX || c == C_CKEH) set_seq(b, 0, -1, -1, -1, -1, -1);
              else took = 1'b0;
      3:      if (c == C_PDX || c == C_CKEH) set_seq(b, 2, -1, -1, -1, -1, -1);
              else took = 1'b0;
      12:     if (c == C_DPDX) set_seq(b, 0, -1, -1, -1, -1, -1);
              else took = 1'b0;
      default: took = 1'b0;
    endcase
  endtask

  task automatic model_step(input logic [18:0] gmask, input logic [18:0] amask,
                            input int g, input int a);
    for (int b = 0; b < NB; b++) begin
      logic [18:0] m;
      int c;
      bit took;
      m = gmask | ((b == g * 4 + a) ? amask : 19'd0);
      c = -1;
      for (int i = 18; i >= 0; i--) if (m[i]) c = i;
      model_cmd(b, c, took);
      if (!took && m_rem[b] > 0) begin
        m_rem[b]--;
        if (m_rem[b] == 0) begin
          m_st[b] = p_st[b][0]; m_rem[b] = p_dur[b][0];
          p_st[b][0] = p_st[b][1]; p_dur[b][0] = p_dur[b][1];
          p_st[b][1] = -1; p_dur[b][1] = -1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_strobes(input logic [18:0] f);
    pra = f[C_PRA]; pr = f[C_PR]; refresh = f[C_REF]; act = f[C_ACT];
    wra = f[C_WRA]; wr = f[C_WR]; rda = f[C_RDA]; rd = f[C_RD]; bst = f[C_BST];
    srf = f[C_SRF]; pd = f[C_PD]; ckel = f[C_CKEL]; pdx = f[C_PDX]; ckeh = f[C_CKEH];
    dpd = f[C_DPD]; dpdx = f[C_DPDX]; mrr = f[C_MRR]; mrw = f[C_MRW]; cfg = f[C_CFG];
  endtask

  task automatic drive(input logic [18:0] gmask, input logic [18:0] amask,
                       input int g, input int a);
    logic [W-1:0] e;
    @(negedge clk);
    bg = 2'(g); ba = 2'(a);
    set_strobes(gmask | amask);
    model_step(gmask, amask, g, a);
    for (int b = 0; b < NB; b++) e[b*5 +: 5] = 5'(m_st[b]);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, 0, 0);
  endtask

  task automatic issue(input int c, input int g, input int a);
    logic [18:0] m;
    m = 19'd1 << c;
    if ((m & ADDR_MASK) != 0) drive('0, m, g, a);
    else drive(m, '0, g, a);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    set_strobes('0);
    reset = 1'b1;
    #1;
    checks++;
    if (bank_fsm !== '0) begin
      errors++;
      $display("FAIL %s: BankFSM=%h expected 0", tag, bank_fsm);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  // Each pushed expectation belongs to the next rising edge after it was driven.
  always @(posedge clk) begin
    logic [W-1:0] e;
    cycle_no++;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bank_fsm !== e) begin
        errors++;
        $display("FAIL bank_fsm cycle %0d: got %h expected %h", cycle_no, bank_fsm, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    do_reset("reset_state");

    idle(2);
    // Activate [1][1], then write, read, precharge.
    issue(C_ACT, 1, 1); idle(17);
    issue(C_WR, 1, 1);  idle(6);
    issue(C_RD, 1, 1);  idle(6);
    issue(C_PR, 1, 1);  idle(18);
    // Refresh all, then PR to an idle bank is ignored.
    issue(C_REF, 0, 0); idle(36);
    issue(C_PR, 0, 0);  idle(2);
    // Write with auto-precharge, PR during WritingAP ignored.
    issue(C_ACT, 2, 3); idle(16);
    issue(C_WRA, 2, 3); idle(3);
    issue(C_PR, 2, 3);  idle(35);
    // Read with auto-precharge.
    issue(C_ACT, 0, 2); idle(16);
    issue(C_RDA, 0, 2); idle(28);
    // ACT to an active bank (RowClone only when enabled).
    issue(C_ACT, 3, 0); idle(16);
    issue(C_ACT, 3, 0); idle(17);
    // Simultaneous strobes resolved by priority.
    drive(19'd1 << C_REF, 19'd1 << C_ACT, 1, 2); idle(3);
    drive('0, (19'd1 << C_WR) | (19'd1 << C_RD), 3, 0); idle(2);
    // Burst restart and terminate.
    issue(C_RD, 3, 0);  idle(1);
    issue(C_BST, 3, 0); idle(2);
    issue(C_WR, 3, 0);  idle(2);
    issue(C_WR, 3, 0);  idle(6);
    idle(34);
    // Global power-state commands.
    issue(C_PD, 0, 0);   idle(2);
    issue(C_CKEH, 0, 0); idle(2);
    issue(C_PRA, 0, 0);  idle(17);
    issue(C_SRF, 0, 0);  idle(2);
    issue(C_PDX, 0, 0);  idle(1);
    issue(C_DPD, 0, 0);  idle(2);
    issue(C_PDX, 0, 0);  idle(1);
    issue(C_DPDX, 0, 0); idle(1);
    issue(C_MRW, 0, 0);  idle(3);
    issue(C_CKEL, 0, 0); idle(1);
    issue(C_CKEH, 0, 0); idle(1);

    // Random command stream.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 55) idle(1);
      else issue($urandom_range(0, 18), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset asserted mid-Activating clears immediately.
    do_reset("reset_clean");
    issue(C_ACT, 2, 2); idle(5);
    do_reset("reset_mid_activating");
    idle(2);
    issue(C_ACT, 2, 2); idle(17);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
